// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, constants and the prefetch entry type for the fetch front-end.
package fetch_pkg;
  localparam int PC_W = 32;
  localparam int INSTR_W = 32;
  localparam logic [PC_W-1:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [PC_W-1:0] PC_STEP = 32'd4;
  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;
  function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] a);
    return a & ~32'd3;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: registered FIFO with synchronous flush; head reads as zero while empty.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_pop;
  assign empty = cnt_q == '0;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign count = cnt_q;
  assign dout = empty ? '0 : mem_q[rd_q];
  assign do_pop = pop && !empty;
  always_comb begin
    mem_d = mem_q;
    mem_d[wr_q] = push ? din : mem_q[wr_q];
    wr_d = flush ? '0 : wr_q + AW'(push);
    rd_d = flush ? '0 : rd_q + AW'(do_pop);
    cnt_d = flush ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/ifetch_prefetch.sv
// ifetch_prefetch: credit-based in-order instruction prefetcher with redirect flush.
module ifetch_prefetch
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic               clk,
  input  logic               rst,
  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic [PC_W-1:0]    mem_req_addr,
  input  logic               mem_rsp_valid,
  input  logic [INSTR_W-1:0] mem_rsp_data,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d, target;
  logic [CW-1:0] inflight_q, inflight_d, stale_q, stale_d, fifo_count;
  logic req_acc, push, fifo_empty, fifo_full;
  fetch_entry_t head;
  assign target = word_align(redirect_pc);
  assign mem_req_valid = !rst && (({1'b0, fifo_count} + {1'b0, inflight_q}) < (CW+1)'(DEPTH));
  assign mem_req_addr = fetch_pc_q;
  assign req_acc = mem_req_valid && mem_req_ready;
  assign push = mem_rsp_valid && stale_q == '0 && !redirect;
  assign instr_valid = !fifo_empty;
  assign instr = head.instr;
  assign instr_pc = head.pc;
  // After a redirect every outstanding request (including one accepted this cycle) is stale.
  always_comb begin
    inflight_d = inflight_q + CW'(req_acc) - CW'(mem_rsp_valid);
    stale_d = redirect ? inflight_d : stale_q - CW'(mem_rsp_valid && stale_q != '0);
    fetch_pc_d = redirect ? target : fetch_pc_q + (req_acc ? PC_STEP : '0);
    rsp_pc_d = redirect ? target : rsp_pc_q + (push ? PC_STEP : '0);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      inflight_q <= '0;
      stale_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q <= rsp_pc_d;
      inflight_q <= inflight_d;
      stale_q <= stale_d;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) assert (!(push && fifo_full));
  end
  sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect),
    .push  (push),
    .din   ({rsp_pc_q, mem_rsp_data}),
    .pop   (instr_ready && !redirect),
    .dout  (head),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );
endmodule

// File: doc/ifetch_prefetch.md
Name: ifetch_prefetch

Overview:
- Instruction fetch front-end that replaces the combinational instruction ROM path.
- Issues in-order word fetches to a latency-tolerant instruction memory (valid/ready request, valid-only response).
- Buffers returned words with their PC in a small prefetch FIFO and presents them to the core's decode stage (instr, pc) via valid/ready.
- Core branch/jump/jr resolution arrives as a redirect that flushes the buffer and drops in-flight responses.

Parameters:
- DEPTH, 4, prefetch FIFO entries and maximum outstanding memory requests; power of two, ≥2.
- RESET_PC, 32'h0000_0000, fetch address after reset.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous active-high reset.
- mem_req_valid  output  1  fetch request valid.
- mem_req_ready  input  1  memory accepts request this cycle.
- mem_req_addr  output  32  word-aligned fetch address (= fetch_pc).
- mem_rsp_valid  input  1  response word valid; responses return in request order, one per request, never before the cycle after acceptance.
- mem_rsp_data  input  32  instruction word.
- instr_valid  output  1  FIFO head valid.
- instr_ready  input  1  decode consumes head.
- instr  output  32  head instruction.
- instr_pc  output  32  head instruction address.
- redirect  input  1  flush and restart fetch.
- redirect_pc  input  32  new fetch address; bits [1:0] ignored (forced 0).

Behaviour:
- Reset (rst high at clock edge): fetch_pc=RESET_PC, FIFO empty, inflight=0, stale=0; mem_req_valid=0, instr_valid=0, instr/instr_pc=0 during and after the reset cycle until data arrives.
- Request issue: mem_req_valid = (fifo_count + inflight < DEPTH). It is independent of redirect and instr_ready. When valid&ready: inflight++ and fetch_pc += 4, wrapping modulo 2^32.
- Response: on mem_rsp_valid, inflight--.
  - If stale>0: the word is discarded and stale--.
  - Otherwise push {fetch address, data} into the FIFO. The address comes from a response-PC register that advances by 4 per accepted non-stale response and is loaded with redirect_pc on redirect.
  - The credit rule guarantees the FIFO never overflows. A push when full is an assertion failure.
- Output: instr_valid = FIFO not empty. Pop on instr_valid&instr_ready. Push and pop in the same cycle keep the count unchanged. A response can appear at the output at the earliest one cycle after it is received (registered FIFO).
- Redirect (single-cycle pulse, highest priority):
  - FIFO flushed (count=0, instr_valid=0 next cycle). A same-cycle pop is ignored.
  - fetch_pc and response-PC load {redirect_pc[31:2],2'b00}.
  - stale = inflight_next_without_flush, i.e. inflight + (req accepted this cycle) − (rsp this cycle). A request accepted in the redirect cycle (old address) is therefore stale. A response in the redirect cycle is discarded, not pushed.
  - Back-to-back redirects: each reloads the PC. The stale count accumulates correctly because stale always equals inflight after a redirect.
- Invariants: stale ≤ inflight ≤ DEPTH; fifo_count + inflight ≤ DEPTH.
- Counter widths: $clog2(DEPTH)+1 bits.
- Reset mid-operation: all counters cleared. The memory is reset by the same rst, so no stale responses survive reset.

Decomposition:
- Package fetch_pkg:
  - PC_W=32, INSTR_W=32.
  - RESET_PC default constant.
  - PC_STEP=4.
  - Typedef of the FIFO entry {pc, instr} (64 bits).
- Sub-module sync_fifo (WIDTH, DEPTH): synchronous flush input, push/pop, count/empty/full outputs. ifetch_prefetch holds the PC registers, credit/inflight/stale counters and redirect logic.

Test Plan:
- Reset then streaming:
  - Stimulus: rst 2 cycles, memory 1-cycle latency always ready, instr_ready=1, imem[0]=0x2008_0005, imem[4]=0x2009_000A.
  - Required: mem_req_addr 0,4,8,…; instr_valid first rises 2 cycles after the first accept; instr_pc 0 with 0x2008_0005, then 4 with 0x2009_000A, one per cycle.
- Backpressure:
  - Stimulus: instr_ready=0 with DEPTH=4.
  - Required: exactly 4 requests accepted (addrs 0..0xC), then mem_req_valid=0. After instr_ready=1, words pop in order 0,4,8,C and requests resume at 0x10.
- Redirect with in-flight requests:
  - Stimulus: memory latency 3, 3 requests outstanding (0x10,0x14,0x18), redirect_pc=0x40.
  - Required: the 3 responses are discarded, FIFO empty next cycle, next request at 0x40, first delivered instr_pc=0x40.
- Same-cycle corner cases:
  - Stimulus: redirect coinciding with a request accept at 0x20, a response, and instr_ready=1.
  - Required: the 0x20 response is discarded, no pop occurs, the next delivered instr_pc=redirect target.
- Misaligned redirect and wrap-around:
  - Stimulus: redirect_pc=0x0000_0107, then separately redirect_pc=0xFFFF_FFFC.
  - Required: fetch at 0x104. For the second case, fetches at 0xFFFF_FFFC then 0x0000_0000, with instr_pc matching.
- Reset mid-stream:
  - Stimulus: rst asserted with FIFO holding 2 entries and 2 requests in flight.
  - Required: next cycle instr_valid=0 and mem_req_valid=0; after release, fetch restarts at RESET_PC.
